// File: rtl/risc_pkg.sv
// Shared defaults for the register file datapath and the address-width derivation.
// Latency: none (definitions only); backpressure: not applicable.
package risc_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int PC_IDX_DEF = 7;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int AW_DEF = addr_width(DEPTH_DEF);

endpackage

// File: rtl/reg_word.sv
// One WIDTH-bit storage word with load enable and async active-low clear.
// Latency: 1 cycle from d/we to q; backpressure: none, a load is always accepted.
module reg_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with a dedicated PC write port and write-through bypass.
// Latency: reads combinational, writes land on the next rising edge; backpressure: none.
module register_file
    import risc_pkg::*;
#(
    parameter int  WIDTH  = WIDTH_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  PC_IDX = PC_IDX_DEF,
    localparam int AW     = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             pc_we,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

    logic             gen_hits_pc;
    logic             pc_take;
    logic [DEPTH-1:0] word_we;
    logic [WIDTH-1:0] word_d [DEPTH];
    logic [WIDTH-1:0] word_q [DEPTH];

    // A general write aimed at the PC slot silently drops the sequential PC update.
    assign gen_hits_pc = we && (wa == PC_ADDR);
    assign pc_take     = pc_we && !gen_hits_pc;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            word_we[i] = we && (wa == AW'(i));
            word_d[i]  = wd;
            if ((i == PC_IDX) && pc_take) begin
                word_we[i] = 1'b1;
                word_d[i]  = pc_in;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        reg_word #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (word_we[g]),
            .d    (word_d[g]),
            .q    (word_q[g])
        );
    end

    function automatic logic [WIDTH-1:0] bypass_read(
        input logic [AW-1:0]    ra,
        input logic [WIDTH-1:0] stored
    );
        if (!rst_n) begin
            return '0;
        end
        if (we && (wa == ra)) begin
            return wd;
        end
        if (pc_take && (ra == PC_ADDR)) begin
            return pc_in;
        end
        return stored;
    endfunction

    always_comb begin
        rd1 = bypass_read(ra1, word_q[ra1]);
        rd2 = bypass_read(ra2, word_q[ra2]);
    end

    assign pc_out = word_q[PC_IDX];

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized checks of register_file against an array-based model.
module tb_register_file;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int PC = 7;
    localparam int AW = 3;

    localparam int W2  = 32;
    localparam int D2  = 16;
    localparam int PC2 = 15;
    localparam int AW2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [AW-1:0] ra1 = '0, ra2 = '0, wa = '0;
    logic [W-1:0]  wd = '0, pc_in = '0;
    logic          we = 1'b0, pc_we = 1'b0;
    logic [W-1:0]  rd1, rd2, pc_out;

    logic [AW2-1:0] ra1_b = '0, ra2_b = '0, wa_b = '0;
    logic [W2-1:0]  wd_b = '0, pc_in_b = '0;
    logic           we_b = 1'b0, pc_we_b = 1'b0;
    logic [W2-1:0]  rd1_b, rd2_b, pc_out_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] mem [D];

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .rd1(rd1), .ra2(ra2), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd),
        .pc_we(pc_we), .pc_in(pc_in), .pc_out(pc_out)
    );

    register_file #(.WIDTH(W2), .DEPTH(D2), .PC_IDX(PC2)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1_b), .rd1(rd1_b), .ra2(ra2_b), .rd2(rd2_b),
        .we(we_b), .wa(wa_b), .wd(wd_b),
        .pc_we(pc_we_b), .pc_in(pc_in_b), .pc_out(pc_out_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What a read port should show right now: reset, then write data, then PC_IN, then storage.
    function automatic logic [W-1:0] expect_read(input logic [AW-1:0] ra);
        if (!rst_n) return '0;
        if (we && int'(wa) == int'(ra)) return wd;
        if (pc_we && int'(ra) == PC) return pc_in;
        return mem[ra];
    endfunction

    task automatic model_edge();
        if (rst_n) begin
            if (pc_we && !(we && int'(wa) == PC)) mem[PC] = pc_in;
            if (we) mem[wa] = wd;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) mem[i] = '0;
    endtask

    // Checks both read ports before the edge, advances one clock, then checks PC_OUT.
    task automatic step(input string tag);
        #1;
        chk({tag, "_rd1"}, 32'(rd1), 32'(expect_read(ra1)));
        chk({tag, "_rd2"}, 32'(rd2), 32'(expect_read(ra2)));
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_pc_out"}, 32'(pc_out), 32'(mem[PC]));
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc_out", 32'(pc_out), 32'h0);
        chk("reset_rd1", 32'(rd1), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill every register with non-zero data.
        for (int i = 0; i < D; i++) begin
            we = 1'b1; wa = AW'(i); wd = W'(16'h1111 * (i + 1));
            step("fill");
        end
        we = 1'b0;

        // Mid-cycle reset with both write enables high clears everything at once.
        we = 1'b1; wa = 3'd2; wd = 16'hBEEF; pc_we = 1'b1; pc_in = 16'h7777;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_async_pc_out", 32'(pc_out), 32'h0);
        for (int i = 0; i < D; i++) begin
            ra1 = AW'(i); ra2 = AW'(D - 1 - i);
            #1;
            chk("rst_async_rd1", 32'(rd1), 32'h0);
            chk("rst_async_rd2", 32'(rd2), 32'h0);
        end
        @(posedge clk);
        #1;
        chk("rst_midwrite_pc_out", 32'(pc_out), 32'h0);
        we = 1'b0; pc_we = 1'b0; ra1 = 3'd2;
        #1;
        chk("rst_midwrite_rd1", 32'(rd1), 32'h0);

        // Release reset mid-cycle with a write pending; it lands on the next edge.
        #2;
        we = 1'b1; wa = 3'd4; wd = 16'h5555; ra1 = 3'd4; ra2 = 3'd2;
        rst_n = 1'b1;
        step("rst_release");
        we = 1'b0;
        #1;
        chk("rst_release_stored", 32'(rd1), 32'h5555);
        @(posedge clk);
        #1;

        // Write 0xA5A5 to r3 then read it back; others unchanged.
        we = 1'b1; wa = 3'd3; wd = 16'hA5A5; ra1 = 3'd0; ra2 = 3'd1;
        step("wr3");
        we = 1'b0; ra1 = 3'd3;
        #1;
        chk("rd_r3", 32'(rd1), 32'hA5A5);
        for (int i = 0; i < D; i++) begin
            ra2 = AW'(i);
            #1;
            chk("others", 32'(rd2), 32'(expect_read(ra2)));
        end

        // Write-through bypass on both ports at once.
        we = 1'b1; wa = 3'd5; wd = 16'h1234; ra1 = 3'd5; ra2 = 3'd5;
        #1;
        chk("bypass_rd1", 32'(rd1), 32'h1234);
        chk("bypass_rd2", 32'(rd2), 32'h1234);
        step("bypass");

        // General write to the PC slot beats the PC port.
        we = 1'b1; wa = 3'd7; wd = 16'h0200; pc_we = 1'b1; pc_in = 16'h0010; ra1 = 3'd7;
        #1;
        chk("pc_conflict_rd1", 32'(rd1), 32'h0200);
        step("pc_conflict");
        chk("pc_conflict_out", 32'(pc_out), 32'h0200);

        // PC increment sequence from 0.
        we = 1'b1; wa = 3'd7; wd = 16'h0; pc_we = 1'b0;
        step("pc_zero");
        we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("pc_inc_out", 32'(pc_out), 32'(k));
            pc_we = 1'b1; pc_in = pc_out + 16'd1; ra1 = 3'd7; ra2 = 3'd0;
            #1;
            chk("pc_inc_bypass", 32'(rd1), 32'(k + 1));
            step("pc_inc");
        end
        pc_we = 1'b0;

        // Wide instance: 32-bit words, 16 registers, PC at 15.
        we_b = 1'b1; wa_b = 4'd15; wd_b = 32'hDEADBEEF; ra1_b = 4'd15;
        #1;
        chk("wide_bypass", rd1_b, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        chk("wide_pc_out", pc_out_b, 32'hDEADBEEF);
        we_b = 1'b0; pc_we_b = 1'b1; pc_in_b = 32'h8765_4321; ra2_b = 4'd15;
        #1;
        chk("wide_pc_bypass", rd2_b, 32'h8765_4321);
        chk("wide_pc_out_hold", pc_out_b, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        chk("wide_pc_update", pc_out_b, 32'h8765_4321);
        pc_we_b = 1'b0;

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 400; n++) begin
            we    = ($urandom_range(0, 2) != 0);
            wa    = AW'($urandom_range(0, D - 1));
            wd    = W'($urandom);
            pc_we = ($urandom_range(0, 1) != 0);
            pc_in = W'($urandom);
            ra1   = AW'($urandom_range(0, D - 1));
            ra2   = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom_range(0, D - 1));
            if ($urandom_range(0, 3) == 0) ra1 = wa;
            if ($urandom_range(0, 5) == 0) ra2 = AW'(PC);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_clear();
            end else begin
                rst_n = 1'b1;
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
